layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer_pkg.sv | 55 +++++
 rtl/layer_sequencer_wb_delay.sv | 44 ++++
 rtl/layer_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// layer_sequencer_pkg
// Shared training-controller definitions: command opcodes, command word field
// layout, sequencer state encoding and small decode helpers.
// -----------------------------------------------------------------------------
package layer_sequencer_pkg;

    // Width of the meaningful part of a command word; bits above are ignored.
    localparam int FIELDS_W = 30;
    localparam int OP_W     = 4;
    localparam int ROWS_W   = 8;
    localparam int COLS_W   = 8;
    localparam int BASE_W   = 10;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD   = 4'd1,
        OP_MATVEC = 4'd2,
        OP_UPDATE = 4'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_WB,
        ST_UPD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Packed MSB-first, so the struct lines up with cmd[29:0]:
    // base [29:20], cols [19:12], rows [11:4], op [3:0].
    typedef struct packed {
        logic [BASE_W-1:0] base;
        logic [COLS_W-1:0] cols;
        logic [ROWS_W-1:0] rows;
        logic [OP_W-1:0]   op;
    } cmd_fields_t;

    function automatic logic cmd_is_legal(input cmd_fields_t f);
        return (f.op inside {OP_LOAD, OP_MATVEC, OP_UPDATE}) &&
               (f.rows != '0) && (f.cols != '0);
    endfunction

    // First working state of a legal command.
    function automatic state_e first_state(input logic [OP_W-1:0] op);
        case (op)
            OP_LOAD:   return ST_LOAD;
            OP_MATVEC: return ST_MAC;
            OP_UPDATE: return ST_UPD;
            default:   return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/layer_sequencer_wb_delay.sv
// -----------------------------------------------------------------------------
// wb_delay
// Fixed-depth delay line that re-times a write strobe and address so they line
// up with read data arriving DEPTH cycles later. Shifts only when advance = 1.
//   clk, reset (async, active-high)
//   advance : shift enable (stall when 0)
//   din     : payload entering the line
//   dout    : payload delayed by DEPTH advancing cycles (din when DEPTH = 0)
// -----------------------------------------------------------------------------
module wb_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
            logic unused_ctrl;
            assign unused_ctrl = clk ^ reset ^ advance;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            // NOTE: the delay line is a short shift register, not a RAM, so it
            // is reset; a stale strobe must never leak into the next command.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else if (advance) begin
                    stage_q[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
// Address/strobe sequencer for a small training engine. Accepts one command at
// a time and walks an R x C tile with running counters:
//   LOAD   : write base+lin for every element.
//   MATVEC : C MAC cycles per row, then one write-back cycle per row.
//   UPDATE : read delta[r] / vec[c], write base+lin RD_LAT cycles later.
// Ports:
//   clk, reset (async, active-high), enable (global advance qualifier)
//   cmd_valid / cmd_ready / cmd[31:0]  : command handshake and word
//   rd_addr_a, rd_addr_b               : weight/delta and vector read addresses
//   wr_addr, wr_en                     : write port
//   mac_en, mac_clr, mac_last          : MAC control strobes
//   busy, done, err                    : status
// -----------------------------------------------------------------------------
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              mac_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DRAIN_LAST = (RD_LAT > 0) ? RD_LAT - 1 : 0;

    state_e state_q, state_d;

    cmd_fields_t fields;
    logic        accept;
    logic        unused_cmd_bits;

    logic [ROWS_W-1:0] rows_q;
    logic [COLS_W-1:0] cols_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] lin_q;
    logic [ROWS_W-1:0] r_q;
    logic [COLS_W-1:0] c_q;      // column counter; doubles as the drain counter
    logic              err_q;

    logic              last_col, last_row;

    // Held copies of the address outputs for cycles with no active strobe.
    logic [ADDR_W-1:0] rd_a_q, rd_b_q, wr_addr_q;

    // Combinational intent for the current state, before enable gating.
    logic              rd_live, wr_live, mac_c, clr_c, last_c, done_c;
    logic [ADDR_W-1:0] rd_a_live, rd_b_live, wr_addr_live;

    // Delay line payload: {strobe, address}.
    logic [ADDR_W:0]   dl_in, dl_out;

    assign fields          = cmd_fields_t'(cmd[FIELDS_W-1:0]);
    assign unused_cmd_bits = ^cmd[31:FIELDS_W];

    assign cmd_ready = (state_q == ST_IDLE) && enable && !reset;
    assign accept    = cmd_valid && cmd_ready;

    assign last_col = (c_q == cols_q - 1'b1);
    assign last_row = (r_q == rows_q - 1'b1);

    assign dl_in = {(state_q == ST_UPD), base_q + lin_q};

    wb_delay #(
        .DEPTH (RD_LAT),
        .WIDTH (ADDR_W + 1)
    ) u_wb_delay (
        .clk     (clk),
        .reset   (reset),
        .advance (enable),
        .din     (dl_in),
        .dout    (dl_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d      = state_q;
        rd_live      = 1'b0;
        wr_live      = 1'b0;
        mac_c        = 1'b0;
        clr_c        = 1'b0;
        last_c       = 1'b0;
        done_c       = 1'b0;
        rd_a_live    = '0;
        rd_b_live    = '0;
        wr_addr_live = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept && cmd_is_legal(fields)) state_d = first_state(fields.op);
            end
            ST_LOAD: begin
                wr_live      = 1'b1;
                wr_addr_live = base_q + lin_q;
                if (last_row && last_col) state_d = ST_DONE;
            end
            ST_MAC: begin
                rd_live   = 1'b1;
                rd_a_live = lin_q;
                rd_b_live = ADDR_W'(c_q);
                mac_c     = 1'b1;
                clr_c     = (c_q == '0);
                last_c    = last_col;
                if (last_col) state_d = ST_WB;
            end
            ST_WB: begin
                wr_live      = 1'b1;
                wr_addr_live = base_q + ADDR_W'(r_q);
                state_d      = last_row ? ST_DONE : ST_MAC;
            end
            ST_UPD: begin
                rd_live      = 1'b1;
                rd_a_live    = ADDR_W'(r_q);
                rd_b_live    = ADDR_W'(c_q);
                wr_live      = dl_out[ADDR_W];
                wr_addr_live = dl_out[ADDR_W-1:0];
                if (last_row && last_col) state_d = (RD_LAT == 0) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                wr_live      = dl_out[ADDR_W];
                wr_addr_live = dl_out[ADDR_W-1:0];
                if (c_q == COLS_W'(DRAIN_LAST)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled cycle freezes the sequence in place.
        if (!enable) state_d = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_q    <= '0;
            cols_q    <= '0;
            base_q    <= '0;
            lin_q     <= '0;
            r_q       <= '0;
            c_q       <= '0;
            err_q     <= 1'b0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            wr_addr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples the values from before the clock edge.
            err_q <= accept && !cmd_is_legal(fields);
            if (enable) begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            rows_q <= fields.rows;
                            cols_q <= fields.cols;
                            base_q <= ADDR_W'(fields.base);
                            lin_q  <= '0;
                            r_q    <= '0;
                            c_q    <= '0;
                        end
                    end
                    ST_LOAD, ST_UPD: begin
                        lin_q <= lin_q + 1'b1;
                        if (last_col) begin
                            c_q <= '0;          // also leaves c_q at 0 for DRAIN
                            r_q <= r_q + 1'b1;
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                    end
                    ST_MAC: begin
                        lin_q <= lin_q + 1'b1;
                        c_q   <= last_col ? '0 : c_q + 1'b1;
                    end
                    ST_WB:    r_q <= r_q + 1'b1;
                    ST_DRAIN: c_q <= c_q + 1'b1;
                    default: ;
                endcase

                if (rd_live) begin
                    rd_a_q <= rd_a_live;
                    rd_b_q <= rd_b_live;
                end
                if (wr_live) wr_addr_q <= wr_addr_live;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign wr_en     = enable && wr_live;
    assign mac_en    = enable && mac_c;
    assign mac_clr   = enable && clr_c;
    assign mac_last  = enable && last_c;
    assign done      = enable && done_c;
    assign err       = enable && err_q;
    assign rd_addr_a = (enable && rd_live) ? rd_a_live : rd_a_q;
    assign rd_addr_b = (enable && rd_live) ? rd_b_live : rd_b_q;
    assign wr_addr   = wr_en ? wr_addr_live : wr_addr_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
// Self-checking bench for layer_sequencer. A reference trace per command is
// built from the operation rules with plain loops and arithmetic, then
// replayed against the DUT cycle by cycle with optional enable stalls.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

    localparam int ADDR_W = 10;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr;
    logic              wr_en, mac_en, mac_clr, mac_last, busy, done, err;

    layer_sequencer #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_last  (mac_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // One enabled cycle of expected activity.
    typedef struct {
        bit       rd;
        bit [9:0] ra, rb;
        bit       wr;
        bit [9:0] wa;
        bit       en, clr, last, done;
    } step_t;

    step_t     trace[$];
    logic [9:0] held_ra, held_rb, held_wa;
    int         n_checks = 0;
    int         n_pass   = 0;

    // Observed vector: {busy, done, err, cmd_ready, wr_en, wr_addr, mac_en,
    // mac_clr, mac_last, rd_addr_a, rd_addr_b}.
    function automatic logic [37:0] sample_outputs();
        return {busy, done, err, cmd_ready, wr_en, wr_addr,
                mac_en, mac_clr, mac_last, rd_addr_a, rd_addr_b};
    endfunction

    task automatic build_trace(input int op, input int rows, input int cols, input int base);
        step_t s;
        int    n;
        trace.delete();
        n = rows * cols;
        case (op)
            1: for (int i = 0; i < n; i++) begin
                   s = '{default: '0};
                   s.wr = 1; s.wa = 10'(base + i);
                   trace.push_back(s);
               end
            2: for (int r = 0; r < rows; r++) begin
                   for (int c = 0; c < cols; c++) begin
                       s = '{default: '0};
                       s.rd = 1; s.ra = 10'(r * cols + c); s.rb = 10'(c);
                       s.en = 1; s.clr = (c == 0); s.last = (c == cols - 1);
                       trace.push_back(s);
                   end
                   s = '{default: '0};
                   s.wr = 1; s.wa = 10'(base + r);
                   trace.push_back(s);
               end
            default: for (int k = 0; k < n + RD_LAT; k++) begin
                   s = '{default: '0};
                   if (k < n) begin
                       s.rd = 1; s.ra = 10'(k / cols); s.rb = 10'(k % cols);
                   end
                   if (k >= RD_LAT) begin
                       s.wr = 1; s.wa = 10'(base + k - RD_LAT);
                   end
                   trace.push_back(s);
               end
        endcase
        s = '{default: '0};
        s.done = 1;
        trace.push_back(s);
    endtask

    // Issue one legal command and score every cycle until the idle cycle after
    // done. stall_mode: 0 none, 1 random, 2 stall_len cycles before step stall_at.
    // abort_after >= 0 returns right after that many steps, leaving it busy.
    task automatic run_cmd(input string name, input int op, input int rows, input int cols,
                           input int base, input int stall_mode, input int stall_at,
                           input int stall_len, input int abort_after);
        int          k = 0;
        int          run_stall = 0;
        int          fixed_stall = 0;
        bit          en;
        step_t       s;
        logic [9:0]  ra, rb, wa;
        logic [37:0] obs, exp_v;

        build_trace(op, rows, cols, base);

        @(negedge clk);
        enable    = 1'b1;
        cmd_valid = 1'b1;
        cmd       = {2'b00, 10'(base), 8'(cols), 8'(rows), 4'(op)};
        #1;
        obs   = sample_outputs();
        exp_v = {4'b0001, 1'b0, held_wa, 3'b000, held_ra, held_rb};
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s accept: got %h expected %h", name, obs, exp_v);
        else n_pass++;

        while (k < trace.size()) begin
            if (abort_after >= 0 && k == abort_after) return;
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd       = $urandom();
            case (stall_mode)
                1:       en = (run_stall >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
                2:       en = !(k == stall_at && fixed_stall < stall_len);
                default: en = 1'b1;
            endcase
            if (en) run_stall = 0;
            else begin
                run_stall++;
                fixed_stall++;
            end
            enable = en;
            #1;
            obs = sample_outputs();
            if (en) begin
                s  = trace[k];
                ra = s.rd ? s.ra : held_ra;
                rb = s.rd ? s.rb : held_rb;
                wa = s.wr ? s.wa : held_wa;
                exp_v = {1'b1, s.done, 2'b00, s.wr, wa, s.en, s.clr, s.last, ra, rb};
                held_ra = ra;
                held_rb = rb;
                held_wa = wa;
                k++;
            end else begin
                exp_v = {4'b1000, 1'b0, held_wa, 3'b000, held_ra, held_rb};
            end
            n_checks++;
            if (obs !== exp_v)
                $display("FAIL %s step %0d en=%0b: got %h expected %h", name, k, en, obs, exp_v);
            else n_pass++;
        end

        @(negedge clk);
        cmd_valid = 1'b0;
        enable    = 1'b1;
        #1;
        obs   = sample_outputs();
        exp_v = {4'b0001, 1'b0, held_wa, 3'b000, held_ra, held_rb};
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s idle_after: got %h expected %h", name, obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [37:0] obs;
        reset     = 1'b1;
        enable    = 1'b1;
        cmd_valid = 1'b0;
        cmd       = '0;
        held_ra   = '0;
        held_rb   = '0;
        held_wa   = '0;
        #3;
        obs = sample_outputs();
        n_checks++;
        if (obs !== 38'h0) $display("FAIL reset_outputs: got %h expected 0", obs);
        else n_pass++;
        @(negedge clk);
        #1;
        obs = sample_outputs();
        n_checks++;
        if (obs !== 38'h0) $display("FAIL reset_hold: got %h expected 0", obs);
        else n_pass++;
        @(posedge clk);
        #2 reset = 1'b0;   // the next rising edge is the first one after release
    endtask

    task automatic test_reject(input string name, input logic [31:0] word);
        logic [37:0] obs, exp_v;
        @(negedge clk);
        enable    = 1'b1;
        cmd_valid = 1'b1;
        cmd       = word;
        #1;
        obs   = sample_outputs();
        exp_v = {4'b0001, 1'b0, held_wa, 3'b000, held_ra, held_rb};
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s accept: got %h expected %h", name, obs, exp_v);
        else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        obs   = sample_outputs();
        exp_v = {4'b0011, 1'b0, held_wa, 3'b000, held_ra, held_rb};
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s err_pulse: got %h expected %h", name, obs, exp_v);
        else n_pass++;
        @(negedge clk);
        #1;
        obs   = sample_outputs();
        exp_v = {4'b0001, 1'b0, held_wa, 3'b000, held_ra, held_rb};
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s err_clear: got %h expected %h", name, obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_mid_update();
        logic [37:0] obs;
        run_cmd("reset_mid_upd", 3, 3, 3, int'($urandom_range(0, 1023)), 0, 0, 0, 4);
        enable    = 1'b1;
        cmd_valid = 1'b0;
        #2 reset  = 1'b1;
        held_ra   = '0;
        held_rb   = '0;
        held_wa   = '0;
        #1;
        obs = sample_outputs();
        n_checks++;
        if (obs !== 38'h0) $display("FAIL reset_mid_upd async: got %h expected 0", obs);
        else n_pass++;
        @(negedge clk);
        #1;
        obs = sample_outputs();
        n_checks++;
        if (obs !== 38'h0) $display("FAIL reset_mid_upd no_done: got %h expected 0", obs);
        else n_pass++;
        @(posedge clk);
        #2 reset = 1'b0;
        run_cmd("load_after_reset", 1, 2, 2, 'h050, 0, 0, 0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_cmd("random", int'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 1023)), 1, 0, 0, -1);
        end
    endtask

    initial begin
        test_reset();
        run_cmd("load_2x3", 1, 2, 3, 'h010, 0, 0, 0, -1);
        run_cmd("matvec_2x2", 2, 2, 2, 'h100, 0, 0, 0, -1);
        run_cmd("matvec_stall", 2, 2, 2, 'h100, 2, 2, 3, -1);
        run_cmd("update_wrap", 3, 1, 2, 'h3FF, 0, 0, 0, -1);
        test_reject("reject_op7", {2'b00, 10'h020, 8'd2, 8'd2, 4'd7});
        test_reject("reject_r0",  {2'b00, 10'h020, 8'd3, 8'd0, 4'd1});
        test_reject("reject_c0",  {2'b00, 10'h020, 8'd0, 8'd3, 4'd2});
        test_reject("reject_op0", {2'b11, 10'h020, 8'd1, 8'd1, 4'd0});
        test_random();
        test_reset_mid_update();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
